// File: rtl/mem_io_bridge.sv
// Memory-stage bus fabric: DMEM routing, GPIO, seven-segment scan, factorial accelerator FSM.
// Optional leading-zero blanking on the display with IO_BRIDGE_ZERO_BLANK_EN.
module mem_io_bridge #(
  parameter logic [31:0] DMEM_TOP    = 32'h0000_07FF,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned FACT_MAX_N  = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        dmem_we,
  input  logic [31:0] dmem_rdata,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  output logic        fact_start,
  output logic [3:0]  fact_n,
  input  logic        fact_done,
  input  logic [31:0] fact_result,
  output logic [7:0]  seven_seg,
  output logic [3:0]  seg_select
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BUSY
  } state_t;

  state_t r_state, w_state_nxt;

  logic [31:0]   r_gpio_out;
  logic [3:0]    r_fact_n;
  logic [15:0]   r_seg;
  logic [31:0]   r_result;
  logic          r_done;
  logic          r_err;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_digit;

  logic [31:0] w_word;
  logic        w_dmem_sel;
  logic        w_io_we;
  logic        w_busy;
  logic        w_go;
  logic        w_n_bad;
  logic        w_accept;
  logic        w_reject;
  logic        w_capture;
  logic [3:0]  w_nib;
  logic [7:0]  w_glyph;
  logic        w_blank;

  assign w_word     = {addr[31:2], 2'b00};
  assign w_dmem_sel = (addr <= DMEM_TOP);
  assign dmem_we    = we & w_dmem_sel;
  // DMEM wins any overlap with the I/O window
  assign w_io_we    = we & ~w_dmem_sel;
  assign w_busy     = (r_state != S_IDLE);
  assign w_go       = w_io_we && (w_word == 32'h804) && wdata[0];
  assign w_n_bad    = (32'(r_fact_n) > FACT_MAX_N);

  assign gpio_out   = r_gpio_out;
  assign fact_n     = r_fact_n;
  assign fact_start = (r_state == S_START);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_go) begin
          if (w_n_bad) begin
            w_reject = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = S_START;
          end
        end
      end
      S_START: w_state_nxt = S_BUSY;
      S_BUSY: begin
        if (fact_done) begin
          w_capture   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end
      if (w_reject) begin
        r_done <= 1'b0;
        r_err  <= 1'b1;
      end
      if (w_capture) begin
        r_result <= fact_result;
        r_done   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gpio_out <= '0;
      r_fact_n   <= '0;
      r_seg      <= '0;
    end else begin
      if (w_io_we && w_word == 32'h904) r_gpio_out <= wdata;
      if (w_io_we && w_word == 32'h908) r_seg <= wdata[15:0];
      // operand frozen while the accelerator owns it
      if (w_io_we && w_word == 32'h800 && !w_busy)
        r_fact_n <= wdata[3:0];
    end
  end

  always_comb begin
    rdata = '0;
    if (w_dmem_sel) begin
      rdata = dmem_rdata;
    end else begin
      unique case (w_word)
        32'h800: rdata = {28'b0, r_fact_n};
        32'h808: rdata = {29'b0, r_err, w_busy, r_done};
        32'h80C: rdata = r_result;
        32'h900: rdata = gpio_in;
        32'h904: rdata = r_gpio_out;
        32'h908: rdata = {16'b0, r_seg};
        default: rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_digit <= '0;
    end else if (r_cnt == CW'(REFRESH_DIV - 1)) begin
      r_cnt   <= '0;
      r_digit <= r_digit + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_nib = r_seg[{r_digit, 2'b00} +: 4];

  always_comb begin
    w_glyph = 8'hFF;
    unique case (w_nib)
      4'h0: w_glyph = 8'hC0;
      4'h1: w_glyph = 8'hF9;
      4'h2: w_glyph = 8'hA4;
      4'h3: w_glyph = 8'hB0;
      4'h4: w_glyph = 8'h99;
      4'h5: w_glyph = 8'h92;
      4'h6: w_glyph = 8'h82;
      4'h7: w_glyph = 8'hF8;
      4'h8: w_glyph = 8'h80;
      4'h9: w_glyph = 8'h90;
      4'hA: w_glyph = 8'h88;
      4'hB: w_glyph = 8'h83;
      4'hC: w_glyph = 8'hC6;
      4'hD: w_glyph = 8'hA1;
      4'hE: w_glyph = 8'h86;
      4'hF: w_glyph = 8'h8E;
      default: w_glyph = 8'hFF;
    endcase
  end

`ifdef IO_BRIDGE_ZERO_BLANK_EN
  always_comb begin
    w_blank = 1'b0;
    unique case (r_digit)
      2'd0: w_blank = 1'b0;
      2'd1: w_blank = (r_seg[15:4] == '0);
      2'd2: w_blank = (r_seg[15:8] == '0);
      2'd3: w_blank = (r_seg[15:12] == '0);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  assign seven_seg  = w_blank ? 8'hFF : w_glyph;
  assign seg_select = ~(4'b0001 << r_digit);

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge: register map, accelerator FSM, display scan.
// Built with REFRESH_DIV=4 so a full scan takes 16 clocks.
module tb_mem_io_bridge;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic        dmem_we;
  logic [31:0] dmem_rdata;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic        fact_start;
  logic [3:0]  fact_n;
  logic        fact_done;
  logic [31:0] fact_result;
  logic [7:0]  seven_seg;
  logic [3:0]  seg_select;

  int checks = 0;
  int errors = 0;

  mem_io_bridge #(
    .DMEM_TOP(32'h0000_07FF),
    .REFRESH_DIV(4),
    .FACT_MAX_N(12)
  ) dut (
    .clk(clk),
    .reset(reset),
    .addr(addr),
    .wdata(wdata),
    .we(we),
    .rdata(rdata),
    .dmem_we(dmem_we),
    .dmem_rdata(dmem_rdata),
    .gpio_in(gpio_in),
    .gpio_out(gpio_out),
    .fact_start(fact_start),
    .fact_n(fact_n),
    .fact_done(fact_done),
    .fact_result(fact_result),
    .seven_seg(seven_seg),
    .seg_select(seg_select)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a;
    wdata = d;
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    addr = 32'hFFF0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a;
    we = 1'b0;
    #1 d = rdata;
  endtask

  task automatic pulse_done(input logic [31:0] res);
    @(negedge clk);
    fact_done = 1'b1;
    fact_result = res;
    @(negedge clk);
    fact_done = 1'b0;
    fact_result = 32'h0;
  endtask

  task automatic count_starts(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      if (fact_start === 1'b1) c++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    checks++;
    if (seg_select !== 4'b1110) begin
      errors++;
      $display("FAIL reset_seg_select got %b want 1110", seg_select);
    end
    checks++;
    if (gpio_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_gpio_out got %h want 0", gpio_out);
    end
    checks++;
    if (fact_start !== 1'b0 || fact_n !== 4'h0) begin
      errors++;
      $display("FAIL reset_fact got start=%b n=%h want 0/0",
               fact_start, fact_n);
    end
    rd(32'h808, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_status got %h want 0", d);
    end
    rd(32'h80C, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_result got %h want 0", d);
    end
    rd(32'h904, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_gpio_rd got %h want 0", d);
    end
  endtask

  task automatic test_bus;
    logic [31:0] d;
    @(negedge clk);
    addr = 32'h904;
    wdata = 32'hDEADBEEF;
    we = 1'b1;
    #1;
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL gpio_old_read got %h want 0", rdata);
    end
    checks++;
    if (dmem_we !== 1'b0) begin
      errors++;
      $display("FAIL io_dmem_we got %b want 0", dmem_we);
    end
    @(negedge clk);
    we = 1'b0;
    checks++;
    if (gpio_out !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL gpio_out got %h want deadbeef", gpio_out);
    end
    rd(32'h904, d);
    checks++;
    if (d !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL gpio_rd got %h want deadbeef", d);
    end
    gpio_in = 32'h1234_5678;
    rd(32'h900, d);
    checks++;
    if (d !== 32'h1234_5678) begin
      errors++;
      $display("FAIL gpio_in_rd got %h want 12345678", d);
    end
    dmem_rdata = 32'hCAFE_F00D;
    rd(32'h100, d);
    checks++;
    if (d !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL dmem_rd got %h want cafef00d", d);
    end
    @(negedge clk);
    addr = 32'h100;
    wdata = 32'h55;
    we = 1'b1;
    #1;
    checks++;
    if (dmem_we !== 1'b1) begin
      errors++;
      $display("FAIL dmem_we_100 got %b want 1", dmem_we);
    end
    addr = 32'h7FF;
    #1;
    checks++;
    if (dmem_we !== 1'b1) begin
      errors++;
      $display("FAIL dmem_we_top got %b want 1", dmem_we);
    end
    addr = 32'hA00;
    wdata = 32'h0;
    #1;
    checks++;
    if (dmem_we !== 1'b0) begin
      errors++;
      $display("FAIL dmem_we_a00 got %b want 0", dmem_we);
    end
    @(negedge clk);
    we = 1'b0;
    checks++;
    if (gpio_out !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL unmapped_wr got %h want deadbeef", gpio_out);
    end
    rd(32'hA00, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL unmapped_rd got %h want 0", d);
    end
    rd(32'h804, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL go_rd got %h want 0", d);
    end
  endtask

  task automatic test_fact;
    logic [31:0] d;
    int c;
    wr(32'h800, 32'h5);
    checks++;
    if (fact_n !== 4'h5) begin
      errors++;
      $display("FAIL fact_n got %h want 5", fact_n);
    end
    wr(32'h804, 32'h1);
    count_starts(6, c);
    checks++;
    if (c != 1) begin
      errors++;
      $display("FAIL start_pulse got %0d want 1", c);
    end
    rd(32'h808, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL status_busy got %h want 2", d);
    end
    wr(32'h800, 32'h9);
    checks++;
    if (fact_n !== 4'h5) begin
      errors++;
      $display("FAIL fact_n_busy got %h want 5", fact_n);
    end
    wr(32'h804, 32'h1);
    count_starts(4, c);
    checks++;
    if (c != 0) begin
      errors++;
      $display("FAIL go_in_busy got %0d starts want 0", c);
    end
    pulse_done(32'd120);
    rd(32'h808, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL status_done got %h want 1", d);
    end
    rd(32'h80C, d);
    checks++;
    if (d !== 32'd120) begin
      errors++;
      $display("FAIL result got %0d want 120", d);
    end
  endtask

  task automatic test_err;
    logic [31:0] d;
    int c;
    wr(32'h800, 32'd13);
    wr(32'h804, 32'h1);
    count_starts(4, c);
    checks++;
    if (c != 0) begin
      errors++;
      $display("FAIL err_no_start got %0d want 0", c);
    end
    rd(32'h808, d);
    checks++;
    if (d !== 32'h4) begin
      errors++;
      $display("FAIL status_err got %h want 4", d);
    end
    wr(32'h800, 32'd3);
    wr(32'h804, 32'h1);
    count_starts(4, c);
    checks++;
    if (c != 1) begin
      errors++;
      $display("FAIL err_retry_start got %0d want 1", c);
    end
    rd(32'h808, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL status_retry got %h want 2", d);
    end
    pulse_done(32'd6);
    rd(32'h80C, d);
    checks++;
    if (d !== 32'd6) begin
      errors++;
      $display("FAIL result_retry got %0d want 6", d);
    end
    wr(32'h800, 32'd12);
    wr(32'h804, 32'h1);
    count_starts(3, c);
    checks++;
    if (c != 1) begin
      errors++;
      $display("FAIL max_n_start got %0d want 1", c);
    end
    pulse_done(32'd479001600);
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    wr(32'h800, 32'd4);
    wr(32'h804, 32'h1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pulse_done(32'd24);
    rd(32'h808, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_status got %h want 0", d);
    end
    rd(32'h80C, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_result got %h want 0", d);
    end
  endtask

  task automatic test_display;
    logic [3:0] prev;
    logic [3:0] exp_sel [4];
    logic [7:0] exp_seg [4];
    int found;
    int d;
    exp_sel[0] = 4'b1110;
    exp_sel[1] = 4'b1101;
    exp_sel[2] = 4'b1011;
    exp_sel[3] = 4'b0111;
    exp_seg[0] = 8'hB0;
    exp_seg[1] = 8'h88;
`ifdef IO_BRIDGE_ZERO_BLANK_EN
    exp_seg[2] = 8'hFF;
    exp_seg[3] = 8'hFF;
`else
    exp_seg[2] = 8'hC0;
    exp_seg[3] = 8'hC0;
`endif
    wr(32'h908, 32'h0000_00A3);
    found = 0;
    prev = seg_select;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (prev == 4'b0111 && seg_select == 4'b1110) found = 1;
      prev = seg_select;
    end
    checks++;
    if (found == 0) begin
      errors++;
      $display("FAIL scan_sync got %b want wrap to 1110", seg_select);
    end
    for (int k = 0; k < 16; k++) begin
      d = k / 4;
      checks++;
      if (seg_select !== exp_sel[d] || seven_seg !== exp_seg[d]) begin
        errors++;
        $display("FAIL scan_%0d got sel=%b seg=%h want sel=%b seg=%h",
                 k, seg_select, seven_seg, exp_sel[d], exp_seg[d]);
      end
      @(negedge clk);
    end
    addr = 32'h908;
    wdata = 32'h0000_00A7;
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    checks++;
    if (seg_select !== 4'b1110 || seven_seg !== 8'hF8) begin
      errors++;
      $display("FAIL seg_update got sel=%b seg=%h want 1110/f8",
               seg_select, seven_seg);
    end
  endtask

  initial begin
    reset = 1'b1;
    addr = 32'hFFF0;
    wdata = 32'h0;
    we = 1'b0;
    dmem_rdata = 32'h0;
    gpio_in = 32'h0;
    fact_done = 1'b0;
    fact_result = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    test_reset;
    test_bus;
    test_fact;
    test_err;
    test_reset_mid;
    test_display;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
